// File: rtl/mem_wb_branch.sv
// rtl/mem_wb_branch.sv - EX/MEM and MEM/WB pipeline registers around a fixed-latency data memory
module mem_wb_branch #(
    parameter int MEM_LATENCY = 2,
    parameter int DEPTH       = 256,
    parameter int ADDR_W      = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [1:0]  EXMWB,
    input  logic [2:0]  EXMM,
    input  logic [31:0] EXALUOut,
    input  logic [31:0] EXMWriteDataIn,
    input  logic [4:0]  regtopass,
    output logic        stall,
    output logic [31:0] MEMALUOut,
    output logic [4:0]  EXMEMRegRd,
    output logic [1:0]  EXMEM_RegWrite,
    output logic [31:0] datatowrite,
    output logic [4:0]  MEMWBRegRd,
    output logic [1:0]  MEMWB_RegWrite
);
    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic [3:0] LAST = 4'(MEM_LATENCY - 1);

    state_t            state;
    logic [3:0]        cnt;

    logic [1:0]        exm_wb;
    logic [2:0]        exm_m;
    logic [31:0]       exm_alu;
    logic [31:0]       exm_wdata;
    logic [4:0]        exm_rd;

    logic [1:0]        mwb_wb;
    logic [31:0]       mwb_alu;
    logic [31:0]       mwb_ldata;
    logic [4:0]        mwb_rd;

    logic [31:0]       mem [DEPTH];
    logic [ADDR_W-1:0] addr;
    logic [31:0]       rdata;
    logic              mem_op;
    logic              done;
    logic              mem_we;
    logic              unused_branch;

    assign addr          = exm_alu[ADDR_W+1:2];
    assign rdata         = mem[addr];
    assign mem_op        = exm_m[0] | exm_m[1];
    assign mem_we        = done & exm_m[0];
    assign unused_branch = exm_m[2];

    // An access finishes on the edge where done is high; until then the EX/MEM copy is held.
    always_comb begin
        done = 1'b0;
        if (state == BUSY)
            done = (cnt == LAST);
        else
            done = mem_op && (MEM_LATENCY == 1);
    end

    assign stall = mem_op & ~done;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            exm_wb    <= '0;
            exm_m     <= '0;
            exm_alu   <= '0;
            exm_wdata <= '0;
            exm_rd    <= '0;
            mwb_wb    <= '0;
            mwb_alu   <= '0;
            mwb_ldata <= '0;
            mwb_rd    <= '0;
        end else begin
            if (!stall) begin
                exm_wb    <= EXMWB;
                exm_m     <= EXMM;
                exm_alu   <= EXALUOut;
                exm_wdata <= EXMWriteDataIn;
                exm_rd    <= regtopass;
            end

            // A bubble while stalled keeps a write-back from being repeated.
            if (stall) begin
                mwb_wb    <= '0;
                mwb_alu   <= '0;
                mwb_ldata <= '0;
                mwb_rd    <= '0;
            end else begin
                mwb_wb    <= exm_wb;
                mwb_alu   <= exm_alu;
                mwb_ldata <= exm_m[1] ? rdata : 32'd0;
                mwb_rd    <= exm_rd;
            end

            case (state)
                IDLE: begin
                    if (stall) begin
                        state <= BUSY;
                        cnt   <= 4'd1;
                    end
                end
                BUSY: begin
                    if (done) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (mem_we)
            mem[addr] <= exm_wdata;
    end

    assign MEMALUOut      = exm_alu;
    assign EXMEMRegRd     = exm_rd;
    assign EXMEM_RegWrite = exm_wb;
    assign MEMWBRegRd     = mwb_rd;
    assign MEMWB_RegWrite = mwb_wb;
    assign datatowrite    = mwb_wb[1] ? mwb_ldata : mwb_alu;
endmodule

// File: tb/tb_mem_wb_branch.sv
// tb/tb_mem_wb_branch.sv - bench for mem_wb_branch at latencies 2 and 4
module tb_mem_wb_branch;
    logic        clock = 1'b0;
    logic        reset;

    logic [1:0]  exmwb  [2];
    logic [2:0]  exmm   [2];
    logic [31:0] exalu  [2];
    logic [31:0] exwd   [2];
    logic [4:0]  rtp    [2];
    logic        stall_o[2];
    logic [31:0] memalu [2];
    logic [4:0]  exmrd  [2];
    logic [1:0]  exmrw  [2];
    logic [31:0] dtw    [2];
    logic [4:0]  mwbrd  [2];
    logic [1:0]  mwbrw  [2];

    typedef struct packed {
        logic [1:0]  wb;
        logic [2:0]  m;
        logic [31:0] alu;
        logic [31:0] wd;
        logic [4:0]  rd;
    } instr_t;

    instr_t      cur   [2];
    int          left  [2];
    logic [1:0]  m_wb  [2];
    logic [31:0] m_alu [2];
    logic [31:0] m_ld  [2];
    logic [4:0]  m_rd  [2];
    bit          m_ldk [2];
    logic [31:0] mmem  [2][256];
    bit          mknown[2][256];

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    mem_wb_branch #(.MEM_LATENCY(2)) u_l2 (
        .clock(clock), .reset(reset),
        .EXMWB(exmwb[0]), .EXMM(exmm[0]), .EXALUOut(exalu[0]),
        .EXMWriteDataIn(exwd[0]), .regtopass(rtp[0]),
        .stall(stall_o[0]), .MEMALUOut(memalu[0]), .EXMEMRegRd(exmrd[0]),
        .EXMEM_RegWrite(exmrw[0]), .datatowrite(dtw[0]),
        .MEMWBRegRd(mwbrd[0]), .MEMWB_RegWrite(mwbrw[0])
    );

    mem_wb_branch #(.MEM_LATENCY(4)) u_l4 (
        .clock(clock), .reset(reset),
        .EXMWB(exmwb[1]), .EXMM(exmm[1]), .EXALUOut(exalu[1]),
        .EXMWriteDataIn(exwd[1]), .regtopass(rtp[1]),
        .stall(stall_o[1]), .MEMALUOut(memalu[1]), .EXMEMRegRd(exmrd[1]),
        .EXMEM_RegWrite(exmrw[1]), .datatowrite(dtw[1]),
        .MEMWBRegRd(mwbrd[1]), .MEMWB_RegWrite(mwbrw[1])
    );

    function automatic int lat(input int d);
        return (d == 0) ? 2 : 4;
    endfunction

    task automatic check(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d: got %h, expected %h", name, d, act, exp);
        end
    endtask

    task automatic model_clear(input int d);
        cur[d]   = '0;
        left[d]  = 1;
        m_wb[d]  = '0;
        m_alu[d] = '0;
        m_ld[d]  = '0;
        m_rd[d]  = '0;
        m_ldk[d] = 1'b1;
    endtask

    // left = edges until the instruction in EX/MEM retires; it waits while left > 1.
    task automatic model_step(input int d);
        int idx;
        if (left[d] > 1) begin
            left[d]--;
            m_wb[d]  = '0;
            m_alu[d] = '0;
            m_ld[d]  = '0;
            m_rd[d]  = '0;
            m_ldk[d] = 1'b1;
        end else begin
            idx      = int'((cur[d].alu >> 2) % 256);
            m_wb[d]  = cur[d].wb;
            m_alu[d] = cur[d].alu;
            m_rd[d]  = cur[d].rd;
            if (cur[d].m[1]) begin
                m_ld[d]  = mmem[d][idx];
                m_ldk[d] = mknown[d][idx];
            end else begin
                m_ld[d]  = '0;
                m_ldk[d] = 1'b1;
            end
            if (cur[d].m[0]) begin
                mmem[d][idx]   = cur[d].wd;
                mknown[d][idx] = 1'b1;
            end
            cur[d]  = {exmwb[d], exmm[d], exalu[d], exwd[d], rtp[d]};
            left[d] = (exmm[d][1:0] != 2'b00) ? lat(d) : 1;
        end
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            model_clear(d);
            for (int a = 0; a < 256; a++) mknown[d][a] = 1'b0;
        end
        forever begin
            @(negedge clock);
            for (int d = 0; d < 2; d++) begin
                if (reset) model_clear(d);
                check("stall", d, 32'(stall_o[d]), 32'(left[d] > 1));
                check("memaluout", d, memalu[d], cur[d].alu);
                check("exmem_rd", d, 32'(exmrd[d]), 32'(cur[d].rd));
                check("exmem_regwrite", d, 32'(exmrw[d]), 32'(cur[d].wb));
                check("memwb_rd", d, 32'(mwbrd[d]), 32'(m_rd[d]));
                check("memwb_regwrite", d, 32'(mwbrw[d]), 32'(m_wb[d]));
                if (!(m_wb[d][1] && !m_ldk[d]))
                    check("datatowrite", d, dtw[d], m_wb[d][1] ? m_ld[d] : m_alu[d]);
            end
            @(posedge clock);
            for (int d = 0; d < 2; d++) begin
                if (reset) model_clear(d);
                else model_step(d);
            end
        end
    end

    task automatic drive(input int d, input logic [1:0] wb, input logic [2:0] m,
                         input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] rd);
        exmwb[d] = wb;
        exmm[d]  = m;
        exalu[d] = alu;
        exwd[d]  = wd;
        rtp[d]   = rd;
    endtask

    // Called just after an edge with the DUT not stalling; returns in the op's final cycle.
    task automatic exec(input int d, input logic [1:0] wb, input logic [2:0] m,
                        input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] rd,
                        output int stalls);
        drive(d, wb, m, alu, wd, rd);
        @(posedge clock); #1;
        stalls = 0;
        while (stall_o[d] && stalls < 20) begin
            stalls++;
            drive(d, 2'b11, 3'b011, $urandom, $urandom, 5'($urandom));
            @(posedge clock); #1;
        end
        if (stall_o[d]) check("stall_timeout", d, 32'(stall_o[d]), 32'd0);
        drive(d, 2'b00, 3'b000, 32'd0, 32'd0, 5'd0);
    endtask

    initial begin
        int s;
        reset = 1'b1;
        for (int d = 0; d < 2; d++) drive(d, 2'b00, 3'b000, 32'd0, 32'd0, 5'd0);
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;

        for (int i = 0; i < 5; i++) begin
            @(posedge clock); #1;
            for (int d = 0; d < 2; d++) begin
                check("idle_stall", d, 32'(stall_o[d]), 32'd0);
                check("idle_memaluout", d, memalu[d], 32'd0);
                check("idle_datatowrite", d, dtw[d], 32'd0);
                check("idle_memwb_regwrite", d, 32'(mwbrw[d]), 32'd0);
            end
        end

        exec(0, 2'b01, 3'b000, 32'h1234, 32'd0, 5'd5, s);
        check("alu_stalls", 0, 32'(s), 32'd0);
        check("alu_memaluout", 0, memalu[0], 32'h1234);
        check("alu_exmem_rd", 0, 32'(exmrd[0]), 32'd5);
        check("alu_exmem_regwrite", 0, 32'(exmrw[0]), 32'd1);
        @(posedge clock); #1;
        check("alu_datatowrite", 0, dtw[0], 32'h1234);
        check("alu_memwb_rd", 0, 32'(mwbrd[0]), 32'd5);
        check("alu_memwb_regwrite", 0, 32'(mwbrw[0]), 32'd1);

        exec(0, 2'b00, 3'b001, 32'h10, 32'hDEADBEEF, 5'd0, s);
        check("l2_store_stalls", 0, 32'(s), 32'd1);
        exec(0, 2'b11, 3'b010, 32'h10, 32'd0, 5'd8, s);
        check("l2_load_stalls", 0, 32'(s), 32'd1);
        check("l2_bubble", 0, 32'(mwbrw[0]), 32'd0);
        @(posedge clock); #1;
        check("l2_load_data", 0, dtw[0], 32'hDEADBEEF);
        check("l2_load_rd", 0, 32'(mwbrd[0]), 32'd8);
        check("l2_load_regwrite", 0, 32'(mwbrw[0]), 32'd3);

        exec(0, 2'b00, 3'b001, 32'h400, 32'hA5A5A5A5, 5'd0, s);
        exec(0, 2'b11, 3'b010, 32'h000, 32'd0, 5'd4, s);
        @(posedge clock); #1;
        check("wrap_load_data", 0, dtw[0], 32'hA5A5A5A5);
        exec(0, 2'b11, 3'b011, 32'h003, 32'h11111111, 5'd3, s);
        @(posedge clock); #1;
        check("rmw_old_data", 0, dtw[0], 32'hA5A5A5A5);
        exec(0, 2'b11, 3'b010, 32'h400, 32'd0, 5'd2, s);
        @(posedge clock); #1;
        check("rmw_new_data", 0, dtw[0], 32'h11111111);

        exec(1, 2'b00, 3'b001, 32'h44, 32'hCAFEF00D, 5'd0, s);
        check("l4_store_stalls", 1, 32'(s), 32'd3);
        exec(1, 2'b11, 3'b010, 32'h44, 32'd0, 5'd9, s);
        check("l4_load_stalls", 1, 32'(s), 32'd3);
        check("l4_bubble", 1, 32'(mwbrw[1]), 32'd0);
        @(posedge clock); #1;
        check("l4_load_data", 1, dtw[1], 32'hCAFEF00D);
        check("l4_load_rd", 1, 32'(mwbrd[1]), 32'd9);

        exec(1, 2'b00, 3'b001, 32'h20, 32'h0, 5'd0, s);
        @(posedge clock); #1;
        drive(1, 2'b00, 3'b001, 32'h20, 32'h12345678, 5'd0);
        @(posedge clock); #1;
        check("abort_stall_before", 1, 32'(stall_o[1]), 32'd1);
        @(posedge clock); #1;
        reset = 1'b1;
        #1;
        check("abort_stall", 1, 32'(stall_o[1]), 32'd0);
        check("abort_memaluout", 1, memalu[1], 32'd0);
        check("abort_exmem_regwrite", 1, 32'(exmrw[1]), 32'd0);
        check("abort_datatowrite", 1, dtw[1], 32'd0);
        drive(1, 2'b00, 3'b000, 32'd0, 32'd0, 5'd0);
        @(posedge clock); #1;
        reset = 1'b0;
        exec(1, 2'b11, 3'b010, 32'h20, 32'd0, 5'd7, s);
        @(posedge clock); #1;
        check("abort_load_data", 1, dtw[1], 32'h0);
        check("abort_load_rd", 1, 32'(mwbrd[1]), 32'd7);

        repeat (3) @(posedge clock);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
